// File: rtl/vsynth_pkg.sv
// vsynth_pkg: widths and limits shared by the key encoder, voice allocator and MIDI stages.
package vsynth_pkg;
    localparam int NOTE_W   = 7;
    localparam int DROP_W   = 8;
    localparam int NOTE_MAX = 127;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [DROP_W-1:0] drop_t;

    function automatic drop_t sat_add(input drop_t a, input logic [4:0] b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + (DROP_W+1)'(b);
        return (s > DROP_MAX) ? drop_t'(DROP_MAX) : s[DROP_W-1:0];
    endfunction
endpackage

// File: rtl/key_event_encoder_if.sv
// key_event_encoder_if: debounced key edges in, note events and drop count out.
interface key_event_encoder_if #(parameter int KEYS = 8);
    logic [KEYS-1:0] key_pedge;
    logic [KEYS-1:0] key_nedge;
    logic ev_valid;
    logic ev_ready;
    logic ev_on;
    vsynth_pkg::note_t ev_note;
    vsynth_pkg::drop_t drop_cnt;

    modport master(input key_pedge, key_nedge, ev_ready, output ev_valid, ev_on, ev_note, drop_cnt);
    modport slave(output key_pedge, key_nedge, ev_ready, input ev_valid, ev_on, ev_note, drop_cnt);
endinterface

// File: rtl/key_event_encoder_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt,
    output logic         gnt_valid
);
    logic [2*N-1:0] rot;
    int off;
    int sum;

    assign rot = {req, req} >> ptr;

    always_comb begin
        off = 0;
        gnt_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
                gnt_valid = 1'b1;
            end
        end
        sum = int'(ptr) + off;
        gnt = W'((sum >= N) ? sum - N : sum);
    end
endmodule

// File: rtl/key_event_encoder.sv
// key_event_encoder: turns per-key press/release pulses into a single note-on/off event stream,
// using phys/rep mismatch as the only buffering and coalescing press/release pairs that never left.
module key_event_encoder
    import vsynth_pkg::*;
#(
    parameter int KEYS      = 8,
    parameter int BASE_NOTE = 60
) (
    input logic clk,
    input logic rst,
    key_event_encoder_if.master bus
);
    localparam int PW = $clog2(KEYS);

    if (KEYS < 2 || KEYS > 16 || BASE_NOTE < 0 || BASE_NOTE + KEYS - 1 > NOTE_MAX) begin : g_bad_param
        $error("key_event_encoder: KEYS/BASE_NOTE out of range");
    end

    logic [KEYS-1:0] phys;
    logic [KEYS-1:0] rep;
    logic [KEYS-1:0] coal;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt;
    logic            gnt_valid;
    logic            load;
    logic [4:0]      n_coal;

    rr_arbiter #(.N(KEYS), .W(PW)) u_rr (
        .req      (phys ^ rep),
        .ptr      (ptr),
        .gnt      (gnt),
        .gnt_valid(gnt_valid)
    );

    assign load = (!bus.ev_valid || bus.ev_ready) && gnt_valid;

    for (genvar k = 0; k < KEYS; k++) begin : g_key
        logic rise, fall, phys_nxt, rep_nxt;
        assign rise     = bus.key_pedge[k] && !bus.key_nedge[k] && !phys[k];
        assign fall     = bus.key_nedge[k] && !bus.key_pedge[k] && phys[k];
        assign phys_nxt = rise ? 1'b1 : fall ? 1'b0 : phys[k];
        assign rep_nxt  = (load && gnt == PW'(k)) ? phys[k] : rep[k];
        // an edge that lands phys back on rep cancels an unsent event
        assign coal[k]  = (rise || fall) && (phys_nxt == rep_nxt);
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                phys[k] <= 1'b0;
                rep[k]  <= 1'b0;
            end else begin
                phys[k] <= phys_nxt;
                rep[k]  <= rep_nxt;
            end
        end
    end

    always_comb begin
        n_coal = '0;
        for (int i = 0; i < KEYS; i++) n_coal = n_coal + 5'(coal[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ev_valid <= 1'b0;
            bus.ev_on    <= 1'b0;
            bus.ev_note  <= '0;
            bus.drop_cnt <= '0;
            ptr          <= '0;
        end else begin
            bus.drop_cnt <= sat_add(bus.drop_cnt, n_coal);
            if (load) begin
                bus.ev_valid <= 1'b1;
                bus.ev_on    <= phys[gnt];
                bus.ev_note  <= NOTE_W'(BASE_NOTE) + NOTE_W'(gnt);
                ptr          <= (gnt == PW'(KEYS - 1)) ? '0 : gnt + PW'(1);
            end else if (bus.ev_ready) begin
                bus.ev_valid <= 1'b0;
            end
        end
    end
endmodule
